// File: rtl/n4_pipe_arbiter.sv
// n4_pipe_arbiter: shares one fixed-latency pipelined unit among NREQ requesters and routes results back by tag.
// Define N4_ARB_RR_EN for round-robin arbitration; left undefined, the lowest requesting index always wins.
module n4_pipe_arbiter #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 6,
    parameter int NREQ    = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ*WIDTH-1:0]        req_data,
    output logic [NREQ-1:0]              gnt,
    output logic                         pu_valid,
    output logic [WIDTH-1:0]             pu_din,
    input  logic [WIDTH-1:0]             pu_dout,
    output logic [NREQ-1:0]              rsp_valid,
    output logic [WIDTH-1:0]             rsp_data,
    output logic [$clog2(LATENCY+2)-1:0] inflight,
    output logic                         busy
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(LATENCY+2);

    logic [IW-1:0]    winner;
    logic             found;
    logic             accept;
    logic             ret;
    logic [LATENCY:0] tag_valid;
    logic [IW-1:0]    tag_id [LATENCY+1];

`ifdef N4_ARB_RR_EN
    logic [IW-1:0] ptr;
    logic [IW-1:0] wrap_winner;
    logic          wrap_found;

    // Lowest request at or above the pointer wins; otherwise wrap to the lowest request overall.
    always_comb begin
        winner      = '0;
        found       = 1'b0;
        wrap_winner = '0;
        wrap_found  = 1'b0;
        for (int i = NREQ-1; i >= 0; i--) begin
            if (req[i]) begin
                wrap_winner = IW'(i);
                wrap_found  = 1'b1;
                if (i >= int'(ptr)) begin
                    winner = IW'(i);
                    found  = 1'b1;
                end
            end
        end
        if (!found) begin
            winner = wrap_winner;
            found  = wrap_found;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (winner == IW'(NREQ-1)) ? '0 : winner + IW'(1);
        end
    end
`else
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = NREQ-1; i >= 0; i--) begin
            if (req[i]) begin
                winner = IW'(i);
                found  = 1'b1;
            end
        end
    end
`endif

    // Grant is forced off during reset so nothing is accepted while state is being cleared.
    always_comb begin
        gnt = '0;
        if (rst_n && en && found) begin
            gnt[winner] = 1'b1;
        end
    end

    assign accept = |(req & gnt);
    assign ret    = tag_valid[LATENCY];
    assign busy   = (inflight != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pu_valid  <= 1'b0;
            pu_din    <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            tag_valid <= '0;
            inflight  <= '0;
            for (int k = 0; k <= LATENCY; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            pu_valid <= accept;
            if (accept) begin
                pu_din <= req_data[int'(winner)*WIDTH +: WIDTH];
            end

            // The tag pipeline runs one stage longer than the unit so the tail lines up with pu_dout.
            tag_valid <= {tag_valid[LATENCY-1:0], accept};
            tag_id[0] <= winner;
            for (int k = 1; k <= LATENCY; k++) begin
                tag_id[k] <= tag_id[k-1];
            end

            rsp_valid <= '0;
            if (ret) begin
                rsp_valid[tag_id[LATENCY]] <= 1'b1;
                rsp_data                   <= pu_dout;
            end

            case ({accept, ret})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end
endmodule

// File: doc/n4_pipe_arbiter.md
# n4_pipe_arbiter

Shares one fixed-latency, non-stallable pipelined unit (a multiplier/adder chain built from delay stages in the n4 CNN datapath) between NREQ requesters. Each cycle it grants at most one request, drives the operand into the shared unit, and carries a requester tag alongside in its own tag pipeline. When the unit's result emerges, the tag routes it back to the originating requester. It sits between the n4 convolution lanes and the shared arithmetic pipeline.

## Interface
- WIDTH, 16, operand/result width
- LATENCY, 6, shared unit latency in cycles, pu_din sample to pu_dout valid; ≥1
- NREQ, 4, number of requesters, 2..8
- clk  in  1  clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  grant enable; 0 blocks new grants, in-flight ops still return
- req  in  NREQ  per-requester request, level
- req_data  in  NREQ*WIDTH  operands, requester k at bits [k*WIDTH +: WIDTH]
- gnt  out  NREQ  combinational one-hot grant; op accepted on edge where req[k]&gnt[k]
- pu_valid  out  1  registered, operand valid toward shared unit
- pu_din  out  WIDTH  registered operand toward shared unit
- pu_dout  in  WIDTH  shared unit result
- rsp_valid  out  NREQ  registered one-hot, result for requester k
- rsp_data  out  WIDTH  registered result
- inflight  out  clog2(LATENCY+2)  ops accepted but not yet returned on rsp
- busy  out  1  inflight != 0

## Operation
- Grant: gnt = 0 when en=0 or req=0; otherwise exactly one bit set, chosen per arbitration policy (see Configuration). gnt depends only on req, en, pointer state; never on pu_dout.
- Accept edge E0: pu_din <= req_data slice of winner, pu_valid <= 1, tag {valid=1, id=winner} enters tag pipeline. No accept: pu_valid <= 0, pu_din holds previous value, tag valid 0.
- Tag pipeline: LATENCY+1 stages of {valid, id}, reset to 0, shift every cycle unconditionally (no backpressure anywhere).
- Return: at edge E0+LATENCY+1, rsp_valid <= onehot(id), rsp_data <= pu_dout as seen in the cycle after edge E0+LATENCY. Otherwise rsp_valid <= 0, rsp_data holds.
- inflight: +1 on accept edge, −1 on edge that asserts rsp_valid; simultaneous both → unchanged. Max value LATENCY+1; never overflows.
- Shared unit has no reset; its output is ignored whenever the tag at the tail is invalid.
- Reset (async, any time): gnt combinationally 0 while rst_n=0; pu_valid=0, pu_din=0, rsp_valid=0, rsp_data=0, all tags invalid, inflight=0, RR pointer=0. In-flight ops are dropped, no response generated after release.

## Timing
- Request-to-response latency: LATENCY+1 cycles from accept edge to rsp_valid assertion edge.
- Throughput: one accept per cycle total; back-to-back accepts to same or different requesters return back-to-back in accept order.
- en deasserted mid-stream: no new accepts from that edge; in-flight responses still arrive on schedule.
- req dropped in same cycle as gnt would be computed: no accept, no pointer change.

## Configuration
- N4_ARB_RR_EN defined: round-robin. Pointer p (reset 0); search starts at p, first set req bit upward with wrap wins; on accept, p <= winner+1 mod NREQ. No accept → p unchanged.
- Undefined: fixed priority, lowest index wins; no pointer register.

## Test plan
- Single op: LATENCY=6, req=0001, req_data[0]=0x1234, unit=pure 6-cycle delay -> pu_valid high 1 cycle after accept; rsp_valid=0001, rsp_data=0x1234 exactly 7 cycles after accept edge; inflight 1 then 0.
- All requesting continuously, RR enabled -> grants 0,1,2,3,0,... one per cycle; responses return in same order, each 7 cycles after its accept; inflight saturates at 7.
- Same stimulus, N4_ARB_RR_EN undefined -> requester 0 granted every cycle, gnt never 0010/0100/1000.
- en dropped after 3 accepts -> gnt=0, pu_valid=0 next cycle, exactly 3 responses still delivered, busy falls after last.
- rst_n pulsed low 3 cycles after 2 accepts -> rsp_valid never asserts for those ops, inflight=0, pu_valid=0 immediately; after release RR starts at requester 0.
- Accept and return on same edge -> inflight unchanged (e.g. stays 7 in steady stream).
